// File: rtl/axis_to_axi4_burst_master.sv
// Byte-stream command engine: turns de-framed command packets into single AXI4 INCR
// bursts and returns a framed reply (header, read data, status byte).
module axis_to_axi4_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BEATS  = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [7:0]                s_axis_tdata,
  input  logic                      s_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [7:0]                m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awlock,
  output logic [3:0]                m_axi_awcache,
  output logic [2:0]                m_axi_awprot,
  output logic [3:0]                m_axi_awqos,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  input  logic [1:0]                m_axi_bresp,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arlock,
  output logic [3:0]                m_axi_arcache,
  output logic [2:0]                m_axi_arprot,
  output logic [3:0]                m_axi_arqos,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int ABYTES = ADDR_WIDTH / 8;
  localparam int BI_W   = $clog2(BYTES);
  localparam int SC_W   = $clog2(BYTES + 1);
  localparam logic [2:0] AXSIZE = 3'($clog2(BYTES));
  localparam logic [7:0] OP_WR = 8'h01;
  localparam logic [7:0] OP_RD = 8'h02;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_WR_DATA, S_WR_B, S_RD_AR, S_RD_DATA, S_DRAIN, S_REPLY_HDR, S_REPLY_STAT
  } state_t;

  state_t state, state_nx;

  logic [7:0]            op_r, len_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [3:0]            hdr_cnt;
  logic                  trunc_r, ovr_r, len_err_r, bad_op_r;
  logic [1:0]            worst_r;
  logic                  aw_pend, w_pend, data_done, w_done, r_done;
  logic [DATA_WIDTH-1:0] wbuf, rbuf;
  logic [BYTES-1:0]      wstrb_r;
  logic [BI_W-1:0]       byte_idx;
  logic [8:0]            beat_cnt, rbeat;
  logic [SC_W-1:0]       ser_cnt;
  logic                  s_rdy, s_hs, m_hs, w_hs, r_hs;
  logic                  op_ok, len_bad, last_in_beat, final_beat, rd_ok, r_err;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] status_byte(input logic bad, input logic lerr, input logic ovr,
                                             input logic trn, input logic [1:0] resp);
    return {bad, lerr, ovr, trn, 2'b00, resp};
  endfunction

  assign op_ok        = (s_axis_tdata == OP_WR) || (s_axis_tdata == OP_RD);
  assign len_bad      = 32'(s_axis_tdata) >= 32'(MAX_BEATS);
  assign last_in_beat = (byte_idx == BI_W'(BYTES - 1));
  assign final_beat   = (beat_cnt == {1'b0, len_r});
  assign rd_ok        = (op_r == OP_RD) && !trunc_r && !len_err_r && !bad_op_r;
  assign r_err        = m_axi_rlast != (rbeat == {1'b0, len_r});

  assign s_axis_tready = s_rdy & ~areset;
  assign s_hs = s_axis_tvalid & s_axis_tready;
  assign m_hs = m_axis_tvalid & m_axis_tready;
  assign w_hs = m_axi_wvalid & m_axi_wready;
  assign r_hs = m_axi_rvalid & m_axi_rready;

  assign m_axi_awvalid = aw_pend;
  assign m_axi_awaddr  = addr_r;
  assign m_axi_awlen   = len_r;
  assign m_axi_awsize  = AXSIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_araddr  = addr_r;
  assign m_axi_arlen   = len_r;
  assign m_axi_arsize  = AXSIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;
  assign m_axi_wvalid  = w_pend;
  assign m_axi_wdata   = wbuf;
  assign m_axi_wstrb   = wstrb_r;
  assign m_axi_wlast   = w_pend && final_beat;

  always_ff @(posedge aclk) begin
    if (areset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    s_rdy         = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state)
      S_IDLE: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid) begin
          if (s_axis_tlast) state_nx = S_REPLY_HDR;
          else              state_nx = op_ok ? S_HDR : S_DRAIN;
        end
      end
      S_HDR: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid) begin
          if (hdr_cnt == 4'd0) begin
            if (s_axis_tlast) state_nx = S_REPLY_HDR;
            else if (len_bad) state_nx = S_DRAIN;
          end else if (hdr_cnt == 4'(ABYTES)) begin
            if (op_r == OP_WR) state_nx = S_WR_DATA;
            else               state_nx = s_axis_tlast ? S_REPLY_HDR : S_DRAIN;
          end else if (s_axis_tlast) begin
            state_nx = S_REPLY_HDR;
          end
        end
      end
      S_WR_DATA: begin
        // Back-pressure the byte stream while an assembled beat waits for wready.
        s_rdy = !w_pend && !data_done;
        if (w_done && !aw_pend) state_nx = S_WR_B;
      end
      S_WR_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nx = ovr_r ? S_DRAIN : S_REPLY_HDR;
      end
      S_RD_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nx = S_RD_DATA;
      end
      S_RD_DATA: begin
        m_axi_rready  = (ser_cnt == '0) && !r_done;
        m_axis_tvalid = (ser_cnt != '0);
        m_axis_tdata  = rbuf[7:0];
        if (r_done && ser_cnt == '0) state_nx = S_REPLY_STAT;
      end
      S_DRAIN: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_nx = S_REPLY_HDR;
      end
      S_REPLY_HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = op_r | 8'h80;
        if (m_axis_tready) state_nx = rd_ok ? S_RD_AR : S_REPLY_STAT;
      end
      S_REPLY_STAT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tdata  = status_byte(bad_op_r, len_err_r, ovr_r, trunc_r, worst_r);
        if (m_axis_tready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      op_r <= '0; len_r <= '0; addr_r <= '0; hdr_cnt <= '0;
      trunc_r <= 1'b0; ovr_r <= 1'b0; len_err_r <= 1'b0; bad_op_r <= 1'b0; worst_r <= '0;
      aw_pend <= 1'b0; w_pend <= 1'b0; data_done <= 1'b0; w_done <= 1'b0; r_done <= 1'b0;
      wbuf <= '0; rbuf <= '0; wstrb_r <= '0; byte_idx <= '0;
      beat_cnt <= '0; rbeat <= '0; ser_cnt <= '0;
    end else begin
      if (state == S_IDLE && s_hs) begin
        op_r      <= s_axis_tdata;
        trunc_r   <= s_axis_tlast && op_ok;
        bad_op_r  <= !op_ok;
        ovr_r     <= 1'b0;
        len_err_r <= 1'b0;
        worst_r   <= '0;
        hdr_cnt   <= '0;
        len_r     <= '0;
        addr_r    <= '0;
        beat_cnt  <= '0;
        byte_idx  <= '0;
        data_done <= 1'b0;
        w_done    <= 1'b0;
        rbeat     <= '0;
        r_done    <= 1'b0;
      end

      if (state == S_HDR && s_hs) begin
        hdr_cnt <= hdr_cnt + 4'd1;
        if (hdr_cnt == 4'd0) begin
          len_r <= s_axis_tdata;
          if (len_bad)      len_err_r <= 1'b1;
          if (s_axis_tlast) trunc_r   <= 1'b1;
        end else begin
          // Little-endian: shifting in from the top leaves byte 0 at the LSB.
          addr_r <= {s_axis_tdata, addr_r[ADDR_WIDTH-1:8]};
          if (hdr_cnt == 4'(ABYTES)) begin
            if (op_r == OP_WR) begin
              aw_pend <= 1'b1;
              if (s_axis_tlast) begin
                trunc_r   <= 1'b1;
                data_done <= 1'b1;
              end
            end else if (!s_axis_tlast) begin
              ovr_r <= 1'b1;
            end
          end else if (s_axis_tlast) begin
            trunc_r <= 1'b1;
          end
        end
      end

      if (state == S_WR_DATA) begin
        if (aw_pend && m_axi_awready) aw_pend <= 1'b0;
        if (s_hs) begin
          wbuf <= {s_axis_tdata, wbuf[DATA_WIDTH-1:8]};
          if (last_in_beat) begin
            byte_idx <= '0;
            w_pend   <= 1'b1;
            wstrb_r  <= '1;
          end else begin
            byte_idx <= byte_idx + BI_W'(1);
          end
          if (last_in_beat && final_beat) begin
            data_done <= 1'b1;
            if (!s_axis_tlast) ovr_r <= 1'b1;
          end else if (s_axis_tlast) begin
            // Early end: a partial beat goes out with no strobes, later beats are padding.
            trunc_r   <= 1'b1;
            data_done <= 1'b1;
            if (!last_in_beat) begin
              w_pend   <= 1'b1;
              wstrb_r  <= '0;
              byte_idx <= '0;
            end
          end
        end else if (trunc_r && !w_pend && !w_done) begin
          w_pend  <= 1'b1;
          wstrb_r <= '0;
          wbuf    <= '0;
        end
        if (w_hs) begin
          w_pend   <= 1'b0;
          beat_cnt <= beat_cnt + 9'd1;
          if (final_beat) w_done <= 1'b1;
        end
      end

      if (state == S_WR_B && m_axi_bvalid) worst_r <= m_axi_bresp;

      if (state == S_RD_DATA) begin
        if (r_hs) begin
          rbuf    <= m_axi_rdata;
          ser_cnt <= SC_W'(BYTES);
          rbeat   <= rbeat + 9'd1;
          worst_r <= resp_max(resp_max(worst_r, m_axi_rresp), r_err ? 2'b10 : 2'b00);
          if (m_axi_rlast) r_done <= 1'b1;
        end else if (m_hs) begin
          rbuf    <= rbuf >> 8;
          ser_cnt <= ser_cnt - SC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_to_axi4_burst_master.sv
// Directed bench for axis_to_axi4_burst_master: stimulus pushes expected AXI and reply
// traffic into queues; independent monitors pop and compare on every handshake.
module tb_axis_to_axi4_burst_master;

  logic        aclk = 1'b0;
  logic        areset;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [7:0]  s_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [7:0]  m_axis_tdata;
  logic        awvalid, awready, awlock, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  awcache, awqos, arcache, arqos, wstrb;
  logic        arvalid, arready, arlock, rvalid, rready, rlast;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ax_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
  typedef struct packed { logic [31:0] data; logic [1:0] resp; logic last; } r_t;

  ax_t        exp_aw[$], exp_ar[$];
  w_t         exp_w[$];
  logic [8:0] exp_m[$];
  r_t         rdq[$];
  logic [7:0] cmd[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] bresp_cfg = 2'b00;
  bit         rand_tready = 1'b0;

  always #5 aclk = ~aclk;

  axis_to_axi4_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BEATS(16)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
    .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
    .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awprot(awprot), .m_axi_awqos(awqos),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
    .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
    .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
    .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arqos(arqos),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp), .m_axi_rlast(rlast)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add_hdr(input logic [7:0] op, input logic [7:0] len, input logic [31:0] addr);
    cmd.push_back(op);
    cmd.push_back(len);
    for (int i = 0; i < 4; i++) cmd.push_back(addr[8*i +: 8]);
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) cmd.push_back(w[8*i +: 8]);
  endtask

  task automatic exp_byte(input logic [7:0] b, input logic last);
    exp_m.push_back({last, b});
  endtask

  task automatic exp_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_m.push_back({1'b0, w[8*i +: 8]});
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    bit done;
    done = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge aclk);
      done = s_axis_tready;
      @(posedge aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!done) chk("s_axis_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_cmd(input bit with_last);
    for (int i = 0; i < cmd.size(); i++) send_byte(cmd[i], with_last && (i == cmd.size() - 1));
    cmd.delete();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_m.size() + exp_aw.size() + exp_w.size() + exp_ar.size()) != 0 && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    chk("completion_timeout", 64'(n < 3000), 64'd1);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  // Reply stream monitor, including hold-stable under back-pressure.
  initial begin
    logic [8:0] e, prev;
    bit stalled;
    stalled = 1'b0;
    prev = '0;
    forever begin
      @(negedge aclk);
      if (stalled && m_axis_tvalid) chk("m_axis_hold", {m_axis_tlast, m_axis_tdata}, prev);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_m.size() == 0) chk("m_axis_unexpected", {m_axis_tlast, m_axis_tdata}, 64'h1ff);
        else begin
          e = exp_m.pop_front();
          chk("m_axis_byte", {m_axis_tlast, m_axis_tdata}, e);
        end
      end
      stalled = m_axis_tvalid && !m_axis_tready && !areset;
      prev    = {m_axis_tlast, m_axis_tdata};
    end
  end

  initial begin
    ax_t e;
    forever begin
      @(negedge aclk);
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) chk("aw_unexpected", {awaddr, awlen}, 64'd0);
        else begin
          e = exp_aw.pop_front();
          chk("aw_addr_len", {awaddr, awlen}, e);
          chk("aw_const", {awsize, awburst, awlock, awcache, awprot, awqos},
              {3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
        end
      end
    end
  end

  initial begin
    ax_t e;
    forever begin
      @(negedge aclk);
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) chk("ar_unexpected", {araddr, arlen}, 64'd0);
        else begin
          e = exp_ar.pop_front();
          chk("ar_addr_len", {araddr, arlen}, e);
          chk("ar_const", {arsize, arburst, arlock, arcache, arprot, arqos},
              {3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
        end
      end
    end
  end

  initial begin
    w_t e;
    forever begin
      @(negedge aclk);
      if (wvalid && wready) begin
        if (exp_w.size() == 0) chk("w_unexpected", {wdata, wstrb, wlast}, 64'd0);
        else begin
          e = exp_w.pop_front();
          if (e.strb != 4'h0) chk("w_data", wdata, e.data);
          chk("w_strb_last", {wstrb, wlast}, {e.strb, e.last});
        end
      end
    end
  end

  // AXI slave model with random ready throttling.
  initial begin
    bit wl_hs, b_hs, ar_hs, r_hs, rst_seen, ar_seen;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
    rvalid = 0; rdata = 0; rresp = 0; rlast = 0; ar_seen = 0;
    forever begin
      @(negedge aclk);
      wl_hs    = wvalid && wready && wlast;
      b_hs     = bvalid && bready;
      ar_hs    = arvalid && arready;
      r_hs     = rvalid && rready;
      rst_seen = areset;
      @(posedge aclk);
      #1;
      if (rst_seen) begin
        bvalid = 0; rvalid = 0; rlast = 0; ar_seen = 0;
      end else begin
        if (b_hs) bvalid = 0;
        if (wl_hs) begin bvalid = 1; bresp = bresp_cfg; end
        if (ar_hs) ar_seen = 1;
        if (r_hs && rdq.size() > 0) begin
          if (rlast) ar_seen = 0;
          void'(rdq.pop_front());
        end
        if (ar_seen && rdq.size() > 0) begin
          rvalid = 1;
          rdata  = rdq[0].data;
          rresp  = rdq[0].resp;
          rlast  = rdq[0].last;
        end else begin
          rvalid = 0;
        end
      end
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      arready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = rand_tready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    areset = 1'b1;
    s_axis_tvalid = 0; s_axis_tdata = 0; s_axis_tlast = 0; m_axis_tready = 1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset_outputs", {s_axis_tready, awvalid, wvalid, arvalid, m_axis_tvalid, bready, rready, wlast}, 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("idle_tready", 64'(s_axis_tready), 64'd1);
    @(posedge aclk);
    #1;

    // Single-beat write.
    bresp_cfg = 2'b00;
    add_hdr(8'h01, 8'h00, 32'h1000_0000);
    add_word(32'hDEAD_BEEF);
    exp_aw.push_back('{32'h1000_0000, 8'h00});
    exp_w.push_back('{32'hDEAD_BEEF, 4'hF, 1'b1});
    exp_byte(8'h81, 1'b0); exp_byte(8'h00, 1'b1);
    send_cmd(1'b1);
    wait_idle();

    // Four-beat read with a SLVERR on beat 2.
    add_hdr(8'h02, 8'h03, 32'h0000_0040);
    exp_ar.push_back('{32'h0000_0040, 8'h03});
    rdq.push_back('{32'h1111_1111, 2'b00, 1'b0});
    rdq.push_back('{32'h2222_2222, 2'b00, 1'b0});
    rdq.push_back('{32'h3333_3333, 2'b10, 1'b0});
    rdq.push_back('{32'h4444_4444, 2'b00, 1'b1});
    exp_byte(8'h82, 1'b0);
    exp_word(32'h1111_1111); exp_word(32'h2222_2222);
    exp_word(32'h3333_3333); exp_word(32'h4444_4444);
    exp_byte(8'h02, 1'b1);
    send_cmd(1'b1);
    wait_idle();

    // Truncated two-beat write: second beat padded, status carries bresp.
    bresp_cfg = 2'b01;
    add_hdr(8'h01, 8'h01, 32'h0000_2000);
    add_word(32'h0403_0201);
    cmd.push_back(8'h05);
    exp_aw.push_back('{32'h0000_2000, 8'h01});
    exp_w.push_back('{32'h0403_0201, 4'hF, 1'b0});
    exp_w.push_back('{32'h0000_0000, 4'h0, 1'b1});
    exp_byte(8'h81, 1'b0); exp_byte(8'h11, 1'b1);
    send_cmd(1'b1);
    wait_idle();

    // Overrun: an extra byte after the only beat.
    bresp_cfg = 2'b00;
    add_hdr(8'h01, 8'h00, 32'h0000_3000);
    add_word(32'h0D0C_0B0A);
    cmd.push_back(8'h0E);
    exp_aw.push_back('{32'h0000_3000, 8'h00});
    exp_w.push_back('{32'h0D0C_0B0A, 4'hF, 1'b1});
    exp_byte(8'h81, 1'b0); exp_byte(8'h20, 1'b1);
    send_cmd(1'b1);
    wait_idle();

    // Length beyond MAX_BEATS: no AR, header drained.
    add_hdr(8'h02, 8'h20, 32'h0000_0100);
    exp_byte(8'h82, 1'b0); exp_byte(8'h40, 1'b1);
    send_cmd(1'b1);
    wait_idle();

    // Bad opcode followed by a read under random reply back-pressure.
    cmd.push_back(8'h55); cmd.push_back(8'hAA); cmd.push_back(8'hBB); cmd.push_back(8'hCC);
    exp_byte(8'hD5, 1'b0); exp_byte(8'h80, 1'b1);
    send_cmd(1'b1);
    wait_idle();
    rand_tready = 1'b1;
    add_hdr(8'h02, 8'h01, 32'h0000_0200);
    exp_ar.push_back('{32'h0000_0200, 8'h01});
    rdq.push_back('{32'hA1B2_C3D4, 2'b00, 1'b0});
    rdq.push_back('{32'h0102_0304, 2'b00, 1'b1});
    exp_byte(8'h82, 1'b0);
    exp_word(32'hA1B2_C3D4); exp_word(32'h0102_0304);
    exp_byte(8'h00, 1'b1);
    send_cmd(1'b1);
    wait_idle();
    rand_tready = 1'b0;

    // Reset in the middle of a write data phase, then a clean write.
    add_hdr(8'h01, 8'h03, 32'h0000_5000);
    cmd.push_back(8'h77); cmd.push_back(8'h66);
    exp_aw.push_back('{32'h0000_5000, 8'h03});
    send_cmd(1'b0);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    exp_aw.delete(); exp_w.delete(); exp_m.delete(); rdq.delete();
    @(negedge aclk);
    chk("midreset_outputs", {awvalid, wvalid, arvalid, m_axis_tvalid, bready, rready, wlast}, 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("post_reset_tready", 64'(s_axis_tready), 64'd1);
    chk("post_reset_valids", {awvalid, wvalid, arvalid, m_axis_tvalid}, 64'd0);
    @(posedge aclk);
    #1;
    add_hdr(8'h01, 8'h01, 32'h0000_3000);
    add_word(32'hCAFE_F00D); add_word(32'h1234_5678);
    exp_aw.push_back('{32'h0000_3000, 8'h01});
    exp_w.push_back('{32'hCAFE_F00D, 4'hF, 1'b0});
    exp_w.push_back('{32'h1234_5678, 4'hF, 1'b1});
    exp_byte(8'h81, 1'b0); exp_byte(8'h00, 1'b1);
    send_cmd(1'b1);
    wait_idle();

    chk("leftover_expected", 64'(exp_m.size() + exp_aw.size() + exp_w.size() + exp_ar.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
